// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory arbiter: FSM encoding,
// master indices and the default bus widths of the processor port.
package mem_arbiter_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef logic [0:0] state_t;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic M_PROC = 1'b0;
    localparam logic M_AUX  = 1'b1;

    function automatic logic other_master(input logic idx);
        return ~idx;
    endfunction

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick; the pointer register lives in the caller.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       pri,
    output logic [1:0] grant,
    output logic       win_idx
);

    always_comb begin
        grant   = 2'b00;
        win_idx = pri;
        case (eligible)
            2'b01: begin
                grant   = 2'b01;
                win_idx = M_PROC;
            end
            2'b10: begin
                grant   = 2'b10;
                win_idx = M_AUX;
            end
            2'b11: begin
                grant   = idx_onehot(pri);
                win_idx = pri;
            end
            default: begin
                grant   = 2'b00;
                win_idx = pri;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between the processor
// and an auxiliary master; registered memory outputs, fixed 2-cycle read return.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q,     state_d;
    logic          pri_q,       pri_d;
    logic [1:0]    gnt_q,       gnt_d;
    logic [1:0]    rd_pend_q,   rd_pend_d;
    logic [1:0]    rvalid_q,    rvalid_d;
    logic [DW-1:0] rdata_q,     rdata_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q,    mem_we_d;

    logic [1:0]    eligible;
    logic [1:0]    pick_grant;
    logic          win_idx;
    logic          any_issue;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // A request whose grant is showing this cycle is the one just served,
    // so it must not be picked again.
    assign eligible = {m1_req & ~gnt_q[1], m0_req & ~gnt_q[0]};

    rr_pick2 u_pick (
        .eligible (eligible),
        .pri      (pri_q),
        .grant    (pick_grant),
        .win_idx  (win_idx)
    );

    always_comb begin
        any_issue = |pick_grant;
        sel_we    = (win_idx == M_AUX) ? m1_we    : m0_we;
        sel_addr  = (win_idx == M_AUX) ? m1_addr  : m0_addr;
        sel_wdata = (win_idx == M_AUX) ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_d     = any_issue ? ST_ISSUE : ST_IDLE;
        pri_d       = any_issue ? other_master(win_idx) : pri_q;
        gnt_d       = pick_grant;
        rd_pend_d   = pick_grant & {2{~sel_we}};
        mem_addr_d  = any_issue ? sel_addr  : mem_addr_q;
        mem_wdata_d = any_issue ? sel_wdata : mem_wdata_q;
        mem_we_d    = any_issue & sel_we;

        // RAM data for the access issued last cycle is valid now.
        rvalid_d = (state_q == ST_ISSUE) ? rd_pend_q : 2'b00;
        rdata_d  = (|rvalid_d) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q     <= ST_IDLE;
            pri_q       <= M_PROC;
            gnt_q       <= '0;
            rd_pend_q   <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pri_q       <= pri_d;
            gnt_q       <= gnt_d;
            rd_pend_q   <= rd_pend_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a combinational-read RAM model; each
// scenario task checks its own expected pulses and data inline.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    logic [15:0] ram [0:255];
    int vecs = 0;
    int miss = 0;

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] = mem_wdata;

    mem_arbiter #(.AW(16), .DW(16)) dut (
        .Clock(clk), .Resetn(resetn),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic do_reset;
        resetn = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, rdata, mem_addr, mem_wdata} !== 53'd0)
            begin miss++; $display("FAIL reset_outputs: got gnt=%b%b rv=%b%b we=%b rdata=%h addr=%h wdata=%h, want all 0",
                m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, rdata, mem_addr, mem_wdata); end
        $display("reset: outputs gnt=%b%b rv=%b%b addr=%h", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_addr);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_m0_read;
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0005;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({m0_gnt, m1_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 1'b0, 16'h0005})
            begin miss++; $display("FAIL t1_issue: got gnt=%b%b we=%b addr=%h, want gnt=10 we=0 addr=0005",
                m0_gnt, m1_gnt, mem_we, mem_addr); end
        @(posedge clk); #1 m0_req = 1'b0;
        @(negedge clk);
        vecs++;
        if ({m0_rvalid, m1_rvalid, m0_gnt, m1_gnt} !== 4'b1000)
            begin miss++; $display("FAIL t1_rvalid: got rv=%b%b gnt=%b%b, want rv=10 gnt=00",
                m0_rvalid, m1_rvalid, m0_gnt, m1_gnt); end
        vecs++;
        if (rdata !== 16'hBEEF)
            begin miss++; $display("FAIL t1_rdata: got %h want beef", rdata); end
        $display("t1: m0 read 0005 -> %h", rdata);
        @(negedge clk);
        vecs++;
        if ({m0_rvalid, m1_rvalid} !== 2'b00)
            begin miss++; $display("FAIL t1_rvalid_pulse: got rv=%b%b want 00", m0_rvalid, m1_rvalid); end
    endtask

    task automatic test_m1_write;
        @(posedge clk); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0010; m1_wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({m1_gnt, m0_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 16'h0010, 16'h1234})
            begin miss++; $display("FAIL t2_write_issue: got gnt1=%b gnt0=%b we=%b addr=%h wdata=%h, want 1 0 1 0010 1234",
                m1_gnt, m0_gnt, mem_we, mem_addr, mem_wdata); end
        @(posedge clk); #1 m1_req = 1'b0;
        @(negedge clk);
        vecs++;
        if ({mem_we, m1_gnt, m1_rvalid} !== 3'b000)
            begin miss++; $display("FAIL t2_we_pulse: got we=%b gnt1=%b rv1=%b, want 000", mem_we, m1_gnt, m1_rvalid); end
        $display("t2: m1 write 0010 <- 1234");
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        @(posedge clk);
        @(posedge clk); #1 m0_req = 1'b0;
        @(negedge clk);
        vecs++;
        if ({m0_rvalid, rdata} !== {1'b1, 16'h1234})
            begin miss++; $display("FAIL t2_readback: got rv0=%b rdata=%h, want 1 1234", m0_rvalid, rdata); end
        $display("t2: m0 read 0010 -> %h", rdata);
    endtask

    task automatic test_alternate;
        logic e_g0, e_g1, e_v0, e_v1;
        do_reset();
        m0_we = 1'b0; m0_addr = 16'h0030;
        m1_we = 1'b0; m1_addr = 16'h0031;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            if (k == 4) begin #1; m0_req = 1'b0; m1_req = 1'b0; end
            @(negedge clk);
            e_g0 = (k <= 4) && (k % 2 == 1);
            e_g1 = (k <= 4) && (k % 2 == 0);
            e_v0 = (k >= 2) && ((k - 1) % 2 == 1);
            e_v1 = (k >= 2) && ((k - 1) % 2 == 0);
            vecs++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== {e_g0, e_g1, e_v0, e_v1})
                begin miss++; $display("FAIL t3_cycle%0d: got gnt=%b%b rv=%b%b, want gnt=%b%b rv=%b%b",
                    k, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, e_g0, e_g1, e_v0, e_v1); end
            if (e_v0 || e_v1) begin
                vecs++;
                if (rdata !== (e_v0 ? 16'h3030 : 16'h3131))
                    begin miss++; $display("FAIL t3_rdata%0d: got %h want %h", k, rdata, e_v0 ? 16'h3030 : 16'h3131); end
            end
            $display("t3: cycle %0d gnt=%b%b rv=%b%b rdata=%h", k, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rdata);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness;
        logic [8:1] tg0, tg1, tv0;
        tg0 = 8'b1010_1001;
        tg1 = 8'b0101_0100;
        tv0 = 8'b0101_0010;
        do_reset();
        m0_we = 1'b0; m0_addr = 16'h0040;
        m1_we = 1'b1; m1_addr = 16'h0041; m1_wdata = 16'h5555;
        m0_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            if (k == 2) begin #1; m1_req = 1'b1; end
            @(negedge clk);
            vecs++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== {tg0[k], tg1[k], tv0[k], 1'b0})
                begin miss++; $display("FAIL t4_cycle%0d: got gnt=%b%b rv=%b%b, want gnt=%b%b rv=%b0",
                    k, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, tg0[k], tg1[k], tv0[k]); end
            if (tv0[k]) begin
                vecs++;
                if (rdata !== 16'h4444)
                    begin miss++; $display("FAIL t4_rdata%0d: got %h want 4444", k, rdata); end
            end
            $display("t4: cycle %0d gnt=%b%b rv=%b%b", k, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_we = 1'b0; m0_addr = 16'h0005; m0_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if (m0_gnt !== 1'b1)
            begin miss++; $display("FAIL t5_pre_gnt: got %b want 1", m0_gnt); end
        resetn = 1'b0; m0_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, rdata, mem_addr, mem_wdata} !== 53'd0)
            begin miss++; $display("FAIL t5_dropped: got gnt=%b%b rv=%b%b we=%b rdata=%h addr=%h, want all 0",
                m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we, rdata, mem_addr); end
        resetn = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0031;
        @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({m0_gnt, m1_gnt} !== 2'b10)
            begin miss++; $display("FAIL t5_first_winner: got gnt=%b%b want 10", m0_gnt, m1_gnt); end
        $display("t5: after mid reset winner gnt=%b%b", m0_gnt, m1_gnt);
        m0_req = 1'b0;
        @(negedge clk);
        m1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_master;
        logic        e_g, e_v;
        logic [15:0] e_d;
        m1_we = 1'b0; m1_addr = 16'h0020; m1_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            if (k == 2) begin #1; m1_addr = 16'h0021; end
            if (k == 4) begin #1; m1_addr = 16'h0022; end
            if (k == 6) begin #1; m1_req = 1'b0; end
            @(negedge clk);
            e_g = (k % 2 == 1) && (k <= 5);
            e_v = (k % 2 == 0);
            vecs++;
            if ({m1_gnt, m1_rvalid, m0_gnt, m0_rvalid} !== {e_g, e_v, 2'b00})
                begin miss++; $display("FAIL t6_cycle%0d: got gnt1=%b rv1=%b gnt0=%b rv0=%b, want %b %b 0 0",
                    k, m1_gnt, m1_rvalid, m0_gnt, m0_rvalid, e_g, e_v); end
            if (e_v) begin
                e_d = 16'hA020 + 16'(k / 2 - 1);
                vecs++;
                if (rdata !== e_d)
                    begin miss++; $display("FAIL t6_rdata%0d: got %h want %h", k, rdata, e_d); end
            end
            $display("t6: cycle %0d gnt1=%b rv1=%b rdata=%h", k, m1_gnt, m1_rvalid, rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i);
        ram[8'h05] = 16'hBEEF;
        ram[8'h20] = 16'hA020;
        ram[8'h21] = 16'hA021;
        ram[8'h22] = 16'hA022;
        ram[8'h30] = 16'h3030;
        ram[8'h31] = 16'h3131;
        ram[8'h40] = 16'h4444;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

        test_reset();
        test_m0_read();
        test_m1_write();
        test_alternate();
        test_fairness();
        test_reset_mid();
        test_single_master();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
